// File: rtl/chroni_vram_arbiter.sv
// Single-port VRAM arbiter: chroni video reads have priority over CPU reads/writes,
// with a burst counter that forces a CPU grant after VID_BURST_MAX video grants.
module chroni_vram_arbiter #(
  parameter int MEM_LATENCY   = 1,
  parameter int VID_BURST_MAX = 8
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [12:0] vid_addr,
  input  logic        vid_rd_req,
  output logic        vid_rd_ack,
  output logic [7:0]  vid_data,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_req,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [12:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VID_RD,
    S_CPU_RD,
    S_CPU_WR,
    S_ACK
  } state_t;

  localparam logic [2:0] LAT_LOAD  = 3'(MEM_LATENCY);
  localparam logic [3:0] BURST_MAX = 4'(VID_BURST_MAX);

  state_t      r_state;
  logic [2:0]  r_lat_cnt;
  logic [3:0]  r_burst_cnt;
  logic        r_vid_rd_ack;
  logic        r_cpu_ack;
  logic [7:0]  r_vid_data;
  logic [7:0]  r_cpu_rdata;
  logic [12:0] r_mem_addr;
  logic [7:0]  r_mem_wdata;
  logic        r_mem_we;

  logic w_guard_hit;
  logic w_vid_grant;

  // Video loses only when the CPU is waiting and the video burst is used up.
  assign w_guard_hit = cpu_req && (r_burst_cnt == BURST_MAX);
  assign w_vid_grant = vid_rd_req && !w_guard_hit;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lat_cnt    <= '0;
      r_burst_cnt  <= '0;
      r_vid_rd_ack <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_vid_data   <= '0;
      r_cpu_rdata  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_vid_grant) begin
            r_mem_addr <= vid_addr;
            r_lat_cnt  <= LAT_LOAD;
            r_state    <= S_VID_RD;
            // Guard not hit here, so the counter is below its limit when cpu_req is high.
            if (cpu_req) begin
              r_burst_cnt <= r_burst_cnt + 4'd1;
            end else begin
              r_burst_cnt <= '0;
            end
          end else if (cpu_req) begin
            r_mem_addr  <= cpu_addr;
            r_burst_cnt <= '0;
            if (cpu_we) begin
              r_mem_wdata <= cpu_wdata;
              r_mem_we    <= 1'b1;
              r_state     <= S_CPU_WR;
            end else begin
              r_lat_cnt <= LAT_LOAD;
              r_state   <= S_CPU_RD;
            end
          end else begin
            r_burst_cnt <= '0;
          end
        end
        S_VID_RD: begin
          if (r_lat_cnt == 3'd0) begin
            r_vid_data   <= mem_rdata;
            r_vid_rd_ack <= 1'b1;
            r_state      <= S_ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        S_CPU_RD: begin
          if (r_lat_cnt == 3'd0) begin
            r_cpu_rdata <= mem_rdata;
            r_cpu_ack   <= 1'b1;
            r_state     <= S_ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt - 3'd1;
          end
        end
        S_CPU_WR: begin
          r_mem_we  <= 1'b0;
          r_cpu_ack <= 1'b1;
          r_state   <= S_ACK;
        end
        S_ACK: begin
          // Requests are ignored here so a requester dropping req on its ack edge is never re-granted.
          r_vid_rd_ack <= 1'b0;
          r_cpu_ack    <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign vid_rd_ack = r_vid_rd_ack;
  assign cpu_ack    = r_cpu_ack;
  assign vid_data   = r_vid_data;
  assign cpu_rdata  = r_cpu_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_chroni_vram_arbiter.sv
// Bench for chroni_vram_arbiter: instance A (latency 1, burst 8), instance B (latency 4, burst 3),
// each with a latency-accurate memory; directed steps followed by a randomized requester phase.
`timescale 1ns/1ps
module tb_chroni_vram_arbiter;

  localparam int LA = 1;
  localparam int BA = 8;
  localparam int LB = 4;
  localparam int BB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory contents before any write: a simple function of the address.
  function automatic logic [7:0] pat(input logic [12:0] a);
    return a[7:0] + 8'h40;
  endfunction

  logic        rst_a, rst_b, mem_clr;
  logic [12:0] a_vid_addr, a_cpu_addr, a_mem_addr;
  logic [7:0]  a_vid_data, a_cpu_wdata, a_cpu_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_vid_req, a_vid_ack, a_cpu_we, a_cpu_req, a_cpu_ack, a_mem_we;
  logic [12:0] b_vid_addr, b_cpu_addr, b_mem_addr;
  logic [7:0]  b_vid_data, b_cpu_wdata, b_cpu_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_vid_req, b_vid_ack, b_cpu_we, b_cpu_req, b_cpu_ack, b_mem_we;

  chroni_vram_arbiter #(.MEM_LATENCY(LA), .VID_BURST_MAX(BA)) dut_a (
    .sys_clk(clk), .reset(rst_a),
    .vid_addr(a_vid_addr), .vid_rd_req(a_vid_req), .vid_rd_ack(a_vid_ack), .vid_data(a_vid_data),
    .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata), .cpu_we(a_cpu_we), .cpu_req(a_cpu_req),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
  );

  chroni_vram_arbiter #(.MEM_LATENCY(LB), .VID_BURST_MAX(BB)) dut_b (
    .sys_clk(clk), .reset(rst_b),
    .vid_addr(b_vid_addr), .vid_rd_req(b_vid_req), .vid_rd_ack(b_vid_ack), .vid_data(b_vid_data),
    .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata), .cpu_we(b_cpu_we), .cpu_req(b_cpu_req),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
  );

  // Memory A: writable, read data valid LA edges after the address.
  logic [7:0]    mem_a [0:8191];
  logic [8191:0] wr_a;
  logic [7:0]    pipe_a [1:4];
  always @(posedge clk) begin
    if (mem_clr) begin
      wr_a <= '0;
    end else if (a_mem_we) begin
      mem_a[a_mem_addr] <= a_mem_wdata;
      wr_a[a_mem_addr]  <= 1'b1;
    end
    pipe_a[1] <= wr_a[a_mem_addr] ? mem_a[a_mem_addr] : pat(a_mem_addr);
    for (int k = 2; k <= 4; k++) pipe_a[k] <= pipe_a[k-1];
  end
  assign a_mem_rdata = pipe_a[LA];

  // Memory B: read-only pattern, LB edges of latency.
  logic [7:0] pipe_b [1:4];
  always @(posedge clk) begin
    pipe_b[1] <= pat(b_mem_addr);
    for (int k = 2; k <= 4; k++) pipe_b[k] <= pipe_b[k-1];
  end
  assign b_mem_rdata = pipe_b[LB];

  // Event counters sampled mid-cycle.
  int a_vack_cnt = 0, a_cack_cnt = 0, a_we_cnt = 0, a_both = 0, a_dbl = 0;
  int b_vack_cnt = 0, b_both = 0;
  logic [12:0] a_we_addr = '0;
  logic [7:0]  a_we_data = '0;
  logic a_vprev = 1'b0, a_cprev = 1'b0;
  always @(negedge clk) begin
    a_vack_cnt <= a_vack_cnt + (a_vid_ack ? 1 : 0);
    a_cack_cnt <= a_cack_cnt + (a_cpu_ack ? 1 : 0);
    a_we_cnt   <= a_we_cnt + (a_mem_we ? 1 : 0);
    a_both     <= a_both + ((a_vid_ack && a_cpu_ack) ? 1 : 0);
    a_dbl      <= a_dbl + (((a_vid_ack && a_vprev) || (a_cpu_ack && a_cprev)) ? 1 : 0);
    a_vprev    <= a_vid_ack;
    a_cprev    <= a_cpu_ack;
    if (a_mem_we) begin
      a_we_addr <= a_mem_addr;
      a_we_data <= a_mem_wdata;
    end
    b_vack_cnt <= b_vack_cnt + (b_vid_ack ? 1 : 0);
    b_both     <= b_both + ((b_vid_ack && b_cpu_ack) ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_vid_read(input logic [12:0] addr, input logic [7:0] exp_d, input string tag);
    int n = 0;
    a_vid_addr = addr;
    a_vid_req  = 1'b1;
    do begin tick(); n++; end while (!a_vid_ack && n < 40);
    a_vid_req = 1'b0;
    $display("vid rd addr=%h data=%h ticks=%0d", addr, a_vid_data, n);
    chk({tag, "_lat"}, n, LA + 2);
    chk({tag, "_data"}, a_vid_data, exp_d);
    tick();
  endtask

  task automatic a_cpu_access(input logic we, input logic [12:0] addr, input logic [7:0] wd,
                              input logic [7:0] exp_d, input string tag);
    int n = 0;
    a_cpu_addr  = addr;
    a_cpu_wdata = wd;
    a_cpu_we    = we;
    a_cpu_req   = 1'b1;
    do begin tick(); n++; end while (!a_cpu_ack && n < 40);
    a_cpu_req = 1'b0;
    a_cpu_we  = 1'b0;
    $display("cpu %s addr=%h wdata=%h rdata=%h ticks=%0d", we ? "wr" : "rd", addr, wd, a_cpu_rdata, n);
    chk({tag, "_lat"}, n, we ? 2 : LA + 2);
    if (!we) chk({tag, "_data"}, a_cpu_rdata, exp_d);
    tick();
  endtask

  // Reference memory view for the random phase.
  logic [7:0] model [int];
  function automatic logic [7:0] exp_rd(input logic [12:0] a);
    return model.exists(int'(a)) ? model[int'(a)] : pat(a);
  endfunction

  int base, base2, nv, nc, vbc, vafter, last_v, gap_bad, n;
  int vpend, cpend, vwait, cwait, vdelay, cdelay, ntx;
  logic [12:0] vaddr, caddr;
  logic [7:0]  cdata;
  logic        cwe;

  initial begin
    // Reset held with every request asserted.
    rst_a = 1'b1; rst_b = 1'b1; mem_clr = 1'b1;
    a_vid_addr = 13'h00AA; a_vid_req = 1'b1;
    a_cpu_addr = 13'h0055; a_cpu_wdata = 8'hC3; a_cpu_we = 1'b1; a_cpu_req = 1'b1;
    b_vid_addr = '0; b_vid_req = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0; b_cpu_we = 1'b0; b_cpu_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst_ctl%0d", i), {a_vid_ack, a_cpu_ack, a_mem_we}, 64'd0);
      chk($sformatf("rst_data%0d", i), {a_mem_addr, a_mem_wdata, a_vid_data, a_cpu_rdata}, 64'd0);
    end
    @(negedge clk); #1;
    chk("rst_no_ack", a_vack_cnt + a_cack_cnt + a_we_cnt, 0);
    rst_a = 1'b0; rst_b = 1'b0; mem_clr = 1'b0;
    a_cpu_req = 1'b0; a_cpu_we = 1'b0;
    a_vid_read(13'h00AA, pat(13'h00AA), "post_rst");

    // Video read, then a CPU read that must leave vid_data alone.
    a_vid_read(13'h0401, 8'h41, "vid401");
    a_cpu_access(1'b0, 13'h0059, 8'h00, 8'h99, "cpu_rd99");
    chk("vid_data_hold", a_vid_data, 8'h41);

    // CPU write then read-back.
    base = a_we_cnt; base2 = a_cack_cnt;
    a_cpu_access(1'b1, 13'h1234, 8'h5A, 8'h00, "cpu_wr");
    chk("wr_strobe_cycles", a_we_cnt - base, 1);
    chk("wr_addr", a_we_addr, 13'h1234);
    chk("wr_data", a_we_data, 8'h5A);
    a_cpu_access(1'b0, 13'h1234, 8'h00, 8'h5A, "cpu_rd5A");
    chk("cpu_ack_count", a_cack_cnt - base2, 2);
    model[32'h1234] = 8'h5A;

    // Starvation guard on A: continuous video plus a held CPU read.
    a_vid_addr = 13'h0100; a_vid_req = 1'b1;
    a_cpu_addr = 13'h0123; a_cpu_we = 1'b0; a_cpu_req = 1'b1;
    nv = 0; nc = 0; vbc = -1; vafter = 0; last_v = -1; gap_bad = 0;
    for (int c = 1; c <= 200 && vafter < 2; c++) begin
      tick();
      if (a_vid_ack) begin
        nv++;
        if (nc != 0) vafter++;
        if (last_v >= 0 && nc == 0 && (c - last_v) != LA + 3) gap_bad++;
        last_v = c;
      end
      if (a_cpu_ack) begin
        nc++;
        vbc = nv;
        a_cpu_req = 1'b0;
        chk("guard_cpu_rdata", a_cpu_rdata, pat(13'h0123));
      end
    end
    a_vid_req = 1'b0;
    $display("guard A: video acks before cpu=%0d cpu acks=%0d video after=%0d", vbc, nc, vafter);
    chk("guard_vid_before_cpu", vbc, BA);
    chk("guard_cpu_acks", nc, 1);
    chk("guard_vid_resumes", vafter, 2);
    chk("guard_vid_spacing", gap_bad, 0);
    chk("guard_vid_data", a_vid_data, pat(13'h0100));
    repeat (8) tick();

    // Requester drops req on the ack edge: one grant per request.
    for (int i = 0; i < 3; i++) begin
      base = a_vack_cnt;
      a_vid_read(13'h0700 + 13'(i), pat(13'h0700 + 13'(i)), $sformatf("ackdrop%0d", i));
      repeat (5) tick();
      chk($sformatf("ackdrop%0d_grants", i), a_vack_cnt - base, 1);
    end

    // Reset in the middle of a long-latency read on B.
    base = b_vack_cnt;
    b_vid_addr = 13'h0777; b_vid_req = 1'b1;
    tick(); tick(); tick();
    rst_b = 1'b1; b_vid_req = 1'b0;
    tick();
    rst_b = 1'b0;
    chk("b_rst_mem_addr", b_mem_addr, 13'h0000);
    repeat (8) tick();
    chk("b_rst_no_ack", b_vack_cnt - base, 0);
    b_vid_req = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!b_vid_ack && n < 40);
    b_vid_req = 1'b0;
    $display("B re-request after reset: data=%h ticks=%0d", b_vid_data, n);
    chk("b_rereq_lat", n, LB + 2);
    chk("b_rereq_data", b_vid_data, pat(13'h0777));
    repeat (3) tick();

    // Starvation guard on B with a burst limit of 3.
    b_vid_addr = 13'h0200; b_cpu_addr = 13'h0300; b_cpu_we = 1'b0;
    b_vid_req = 1'b1; b_cpu_req = 1'b1;
    nv = 0; nc = 0; vbc = -1;
    for (int c = 0; c < 200 && nc == 0; c++) begin
      tick();
      if (b_vid_ack) nv++;
      if (b_cpu_ack) begin
        nc++;
        vbc = nv;
        b_cpu_req = 1'b0;
        b_vid_req = 1'b0;
        chk("b_guard_rdata", b_cpu_rdata, pat(13'h0300));
      end
    end
    $display("guard B: video acks before cpu=%0d", vbc);
    chk("b_guard_vid_before_cpu", vbc, BB);
    chk("b_acks_exclusive", b_both, 0);
    repeat (3) tick();

    // Randomized traffic on A against the reference memory view.
    vpend = 0; cpend = 0; vwait = 0; cwait = 0; vdelay = 0; cdelay = 0; ntx = 0;
    for (int c = 0; c < 4000 && ntx < 80; c++) begin
      if (vpend == 0) begin
        if (vdelay > 0) vdelay--;
        else begin
          vaddr = 13'h1230 + 13'($urandom_range(0, 7));
          a_vid_addr = vaddr; a_vid_req = 1'b1; vpend = 1; vwait = 0;
        end
      end
      if (cpend == 0) begin
        if (cdelay > 0) cdelay--;
        else begin
          caddr = 13'h1230 + 13'($urandom_range(0, 7));
          cdata = 8'($urandom);
          cwe   = 1'($urandom_range(0, 1));
          a_cpu_addr = caddr; a_cpu_wdata = cdata; a_cpu_we = cwe; a_cpu_req = 1'b1;
          cpend = 1; cwait = 0;
        end
      end
      tick();
      if (vpend != 0) vwait++;
      if (cpend != 0) cwait++;
      chk("rnd_ack_exclusive", {a_vid_ack, a_cpu_ack} == 2'b11, 1'b0);
      if (a_vid_ack) begin
        $display("rnd vid rd addr=%h data=%h wait=%0d", vaddr, a_vid_data, vwait);
        chk("rnd_vid_pending", vpend, 1);
        chk("rnd_vid_data", a_vid_data, exp_rd(vaddr));
        chk("rnd_vid_wait_bound", vwait <= 3 * (LA + 3), 1'b1);
        a_vid_req = 1'b0; vpend = 0; vdelay = $urandom_range(0, 3); ntx++;
      end
      if (a_cpu_ack) begin
        $display("rnd cpu %s addr=%h wdata=%h rdata=%h wait=%0d", cwe ? "wr" : "rd", caddr, cdata, a_cpu_rdata, cwait);
        chk("rnd_cpu_pending", cpend, 1);
        if (cwe) model[int'(caddr)] = cdata;
        else chk("rnd_cpu_rdata", a_cpu_rdata, exp_rd(caddr));
        chk("rnd_cpu_wait_bound", cwait <= (BA + 1) * (LA + 3) + LA + 3, 1'b1);
        a_cpu_req = 1'b0; a_cpu_we = 1'b0; cpend = 0; cdelay = $urandom_range(0, 3); ntx++;
      end
    end
    a_vid_req = 1'b0; a_cpu_req = 1'b0;
    chk("rnd_tx_count", ntx >= 80, 1'b1);
    repeat (3) tick();
    chk("a_acks_exclusive", a_both, 0);
    chk("a_ack_single_cycle", a_dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
